clockdiv_multi: RTL and testbench

//   Parametrised successor to the fixed-tap clock divider. NUM_CH independent

---
 rtl/clockdiv_multi_if.sv | 36 +++
 rtl/clockdiv_multi.sv | 123 ++++++++++++
 tb/tb_clockdiv_multi.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/clockdiv_multi_if.sv
// Configuration bus and per-channel outputs of the multi-channel clock divider.
// Optional macro CLKDIV_FREEZE_EN adds the freeze input.
interface clockdiv_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int CH_W   = 4
);
    logic              restart;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] cfg_pending;
`ifdef CLKDIV_FREEZE_EN
    logic              freeze;
`endif

    // Controller side: drives configuration, observes the channel outputs.
    modport master (
        output restart, cfg_we, cfg_ch, cfg_div,
`ifdef CLKDIV_FREEZE_EN
        output freeze,
`endif
        input  tick, sq, cfg_pending
    );

    // Divider side.
    modport slave (
        input  restart, cfg_we, cfg_ch, cfg_div,
`ifdef CLKDIV_FREEZE_EN
        input  freeze,
`endif
        output tick, sq, cfg_pending
    );
endinterface

// File: rtl/clockdiv_multi.sv
// clockdiv_multi: NUM_CH independent runtime-programmable dividers on the
// master clock. Each channel emits a one-cycle tick strobe every div_act+1
// cycles and a square wave toggling on each tick. Divisor changes are staged
// and take effect only at the channel's terminal count (glitch-free).
// Optional macro CLKDIV_FREEZE_EN adds a freeze input that holds all channels.
module clockdiv_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 24,
    parameter int DIV_INIT = 1,
    parameter int CH_W     = 4
) (
    input  logic                clk,
    input  logic                clr,
    clockdiv_multi_if.slave     bus
);

    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [CNT_W-1:0]  div_act_q  [NUM_CH];
    logic [CNT_W-1:0]  div_act_d  [NUM_CH];
    logic [CNT_W-1:0]  div_pend_q [NUM_CH];
    logic [CNT_W-1:0]  div_pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] sq_q,   sq_d;
    logic [NUM_CH-1:0] wr_sel;
    logic              hold;

`ifdef CLKDIV_FREEZE_EN
    assign hold = bus.freeze;
`else
    assign hold = 1'b0;
`endif

    // Decode the write strobe; an out-of-range cfg_ch matches no channel.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        end
    end

    // Per-channel next state: restart, then freeze, then normal counting.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            div_act_d[i]  = div_act_q[i];
            div_pend_d[i] = div_pend_q[i];
            pend_d[i]     = pend_q[i];
            tick_d[i]     = 1'b0;
            sq_d[i]       = sq_q[i];

            if (bus.restart) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
                if (pend_q[i]) begin
                    div_act_d[i] = div_pend_q[i];
                end
                pend_d[i] = 1'b0;
                // A write coinciding with restart bypasses staging.
                if (wr_sel[i]) begin
                    div_act_d[i] = bus.cfg_div;
                end
            end else if (hold) begin
                if (wr_sel[i]) begin
                    div_pend_d[i] = bus.cfg_div;
                    pend_d[i]     = 1'b1;
                end
            end else begin
                if (cnt_q[i] == div_act_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                    if (pend_q[i]) begin
                        div_act_d[i] = div_pend_q[i];
                        pend_d[i]    = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                // Staged after any apply above, so a write on the terminal
                // cycle waits for the following boundary.
                if (wr_sel[i]) begin
                    div_pend_d[i] = bus.cfg_div;
                    pend_d[i]     = 1'b1;
                end
            end
        end
    end

    // Counter, active divisor and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= CNT_W'(DIV_INIT);
            end
            pend_q <= '0;
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_act_q[i] <= div_act_d[i];
            end
            pend_q <= pend_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    // Staged divisor is only consumed when pend is set, so it needs no clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_pend_q[i] <= div_pend_d[i];
        end
    end

    assign bus.tick        = tick_q;
    assign bus.sq          = sq_q;
    assign bus.cfg_pending = pend_q;

endmodule

// File: tb/tb_clockdiv_multi.sv
// Directed bench for clockdiv_multi with a cycle scoreboard driven by a
// behavioural channel model, plus fixed-value checks at key cycles.
module tb_clockdiv_multi;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int DIV_INIT = 1;
    localparam int CH_W     = 4;

    logic clk = 1'b0;
    logic clr;

    clockdiv_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    clockdiv_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [CNT_W-1:0]    m_cnt  [NUM_CH];
    logic [CNT_W-1:0]    m_div  [NUM_CH];
    logic [CNT_W-1:0]    m_pdiv [NUM_CH];
    logic [NUM_CH-1:0]   m_pend, m_sq, m_tick;
    logic [3*NUM_CH-1:0] exp_q[$];

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        for (int i = 0; i < NUM_CH; i++) begin
            bit wr;
            wr = bus.cfg_we && (int'(bus.cfg_ch) == i);
            if (clr) begin
                m_cnt[i]  = '0;
                m_div[i]  = CNT_W'(DIV_INIT);
                m_pend[i] = 1'b0;
                m_tick[i] = 1'b0;
                m_sq[i]   = 1'b0;
            end else if (bus.restart) begin
                m_cnt[i]  = '0;
                m_tick[i] = 1'b0;
                m_sq[i]   = 1'b0;
                if (m_pend[i]) m_div[i] = m_pdiv[i];
                m_pend[i] = 1'b0;
                if (wr) m_div[i] = bus.cfg_div;
            end
`ifdef CLKDIV_FREEZE_EN
            else if (bus.freeze) begin
                m_tick[i] = 1'b0;
                if (wr) begin
                    m_pdiv[i] = bus.cfg_div;
                    m_pend[i] = 1'b1;
                end
            end
`endif
            else begin
                if (m_cnt[i] == m_div[i]) begin
                    m_cnt[i]  = '0;
                    m_tick[i] = 1'b1;
                    m_sq[i]   = ~m_sq[i];
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 1'b0;
                    end
                end else begin
                    m_cnt[i]  = m_cnt[i] + 1'b1;
                    m_tick[i] = 1'b0;
                end
                if (wr) begin
                    m_pdiv[i] = bus.cfg_div;
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    // One clock: predict, push, clock, then pop and compare just after the edge.
    task automatic step();
        logic [3*NUM_CH-1:0] got, exp;
        model_update();
        exp_q.push_back({m_pend, m_sq, m_tick});
        @(posedge clk);
        #1;
        cyc++;
        got = {bus.cfg_pending, bus.sq, bus.tick};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL scoreboard cyc=%0d {pend,sq,tick} got=%h exp=%h", cyc, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        clr         = 1'b1;
        bus.restart = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.cfg_ch  = '0;
        bus.cfg_div = '0;
`ifdef CLKDIV_FREEZE_EN
        bus.freeze  = 1'b0;
`endif
        #1;
        step();
        step();
        chk("reset_tick", 32'(bus.tick), 0);
        chk("reset_sq",   32'(bus.sq), 0);
        chk("reset_pend", 32'(bus.cfg_pending), 0);

        // Default divisor 1: tick on even cycles, sq toggles there.
        clr = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("t1_tick0", 32'(bus.tick[0]), 32'(c % 2 == 0));
            chk("t1_sq0",   32'(bus.sq[0]),   32'((c / 2) % 2));
        end

        // ch2 divisor 4 written with cnt=0: one more 2-cycle period, then 5.
        bus.cfg_we = 1'b1; bus.cfg_ch = 4'd2; bus.cfg_div = 8'd4;
        step();
        bus.cfg_we = 1'b0;
        chk("t2_pend_set", 32'(bus.cfg_pending[2]), 1);
        step();
        chk("t2_tick_old", 32'(bus.tick[2]), 1);
        chk("t2_pend_clr", 32'(bus.cfg_pending[2]), 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t2_tick_new", 32'(bus.tick[2]), 32'(k % 5 == 0));
        end

        // ch1 divisor 0 written on its terminal cycle: applied one period later.
        step();
        bus.cfg_we = 1'b1; bus.cfg_ch = 4'd1; bus.cfg_div = 8'd0;
        step();
        bus.cfg_we = 1'b0;
        chk("t3_tick_term", 32'(bus.tick[1]), 1);
        chk("t3_pend_term", 32'(bus.cfg_pending[1]), 1);
        step();
        chk("t3_tick_mid", 32'(bus.tick[1]), 0);
        step();
        chk("t3_apply_tick", 32'(bus.tick[1]), 1);
        chk("t3_apply_pend", 32'(bus.cfg_pending[1]), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_div0_tick", 32'(bus.tick[1]), 1);
            chk("t3_div0_sq",   32'(bus.sq[1]), 32'(k % 2 == 0));
        end

        // Divisors 2,3,6 via restart-time writes, run, then phase-align.
        bus.restart = 1'b1; bus.cfg_we = 1'b1;
        bus.cfg_ch = 4'd0; bus.cfg_div = 8'd2; step();
        bus.cfg_ch = 4'd1; bus.cfg_div = 8'd3; step();
        bus.cfg_ch = 4'd2; bus.cfg_div = 8'd6; step();
        bus.restart = 1'b0; bus.cfg_we = 1'b0;
        for (int k = 0; k < 50; k++) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("t4_restart_tick", 32'(bus.tick), 0);
        chk("t4_restart_sq",   32'(bus.sq), 0);
        for (int k = 1; k <= 84; k++) begin
            step();
            chk("t4_phase", 32'(bus.tick[2:0]),
                32'({k % 7 == 0, k % 4 == 0, k % 3 == 0}));
        end
        chk("t4_lcm", 32'(bus.tick[2:0]), 32'h7);

        // Out-of-range channel write is ignored; clr drops everything.
        bus.cfg_we = 1'b1; bus.cfg_ch = 4'd7; bus.cfg_div = 8'd5;
        step();
        chk("t5_bad_ch", 32'(bus.cfg_pending), 0);
        bus.cfg_ch = 4'd3; bus.cfg_div = 8'd9;
        step();
        bus.cfg_we = 1'b0;
        chk("t5_pend3", 32'(bus.cfg_pending[3]), 1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_clr_tick", 32'(bus.tick), 0);
        chk("t5_clr_sq",   32'(bus.sq), 0);
        chk("t5_clr_pend", 32'(bus.cfg_pending), 0);
        step();
        chk("t5_init_c1", 32'(bus.tick), 0);
        step();
        chk("t5_init_c2", 32'(bus.tick), 32'hF);

`ifdef CLKDIV_FREEZE_EN
        // ch0 divisor 5, count to 3, freeze 10 cycles, resume.
        bus.restart = 1'b1; bus.cfg_we = 1'b1;
        bus.cfg_ch = 4'd0; bus.cfg_div = 8'd5;
        step();
        bus.restart = 1'b0; bus.cfg_we = 1'b0;
        step(); step(); step();
        bus.freeze = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6_frz_tick", 32'(bus.tick), 0);
            chk("t6_frz_sq0",  32'(bus.sq[0]), 0);
        end
        bus.freeze = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t6_resume", 32'(bus.tick[0]), 32'(k == 3));
        end
`endif

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
